posit_encoder: RTL and testbench
================================

# posit_encoder

Pipelined posit packer that assembles an N-bit posit from decoded fields: sign, regime value k, exponent, and fraction. It is the inverse of the regime leading-bit detection path and sits at the output of the adder datapath. It generates the regime run, concatenates the exponent and fraction, rounds to nearest-even, and applies two's-complement for negative values. It uses a two-stage valid/ready pipeline with backpressure.

## Interface
- N, 8, posit width
- ES, 3, exponent field width
- RS, $clog2(N), regime index width; k is RS+1 bits signed
- FW, N, input fraction width (hidden bit excluded, MSB-aligned)
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input fields valid
- in_ready  output  1  block can accept input this cycle
- in_sign  input  1  sign of value
- in_zero  input  1  value is zero (overrides other fields)
- in_nar  input  1  value is NaR (overrides in_zero and other fields)
- in_k  input  RS+1  signed regime value
- in_exp  input  ES  exponent
- in_frac  input  FW  fraction bits after the hidden 1, MSB first
- out_valid  output  1  out_posit valid
- out_ready  input  1  consumer accepts out_posit
- out_posit  output  N  encoded posit

## Operation
- **Regime.**
  - k ≥ 0: (k+1) ones followed by a zero, length k+2.
  - k < 0: (−k) zeros followed by a one, length −k+1.
- **Magnitude body.** Form the vector {regime, in_exp, in_frac}, left-aligned. Keep the top N−1 bits.
  - Guard = the next bit.
  - Sticky = OR of all remaining bits.
- **Rounding.** Round to nearest, ties to even, on the magnitude before negation.
  - Increment if guard & (lsb | sticky).
- **Saturation.**
  - k ≥ N−2: magnitude = maxpos (all N−1 bits one).
  - k ≤ −(N−1): magnitude = minpos (…0001).
  - Rounding never produces the NaR pattern; clamp to maxpos.
  - A nonzero value never rounds to 0; clamp to minpos.
- **Sign.** Result = {0, magnitude}. If in_sign, out_posit = two's complement of the result.
- **Specials.**
  - in_nar → 1 followed by N−1 zeros.
  - else in_zero → all zeros.
  - Specials bypass rounding but traverse the same pipeline.
- **Stage 1 (S1).** Decode specials, compute regime length, shift-build the body, extract guard and sticky. Register with s1_valid.
- **Stage 2 (S2).** Round, saturate, negate. Register as out_posit with out_valid.
- **Handshake.**
  - Transfer occurs when valid & ready are high on the same edge.
  - S2 loads when !out_valid | out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid | S2 loads.
  - out_posit is held stable while out_valid & !out_ready.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no stalls.
- Throughput: 1 result per cycle while out_ready stays high.
- Reset:
  - s1_valid = 0, out_valid = 0, out_posit = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation drops both in-flight entries. Nothing is emitted afterward.
- Backpressure holding two entries: in_ready = 0. Its combinational dependence on out_ready is permitted.
- Simultaneous out_ready and in_valid with a full pipeline: both stages advance and the new input is accepted in the same cycle. No bubble.
- in_* fields are sampled only on transfer. Values while in_valid = 0 are don't-care.

## Structure
- Shared package posit_pkg provides:
  - N/ES/RS defaults;
  - the NaR and zero pattern functions;
  - maxpos/minpos constant functions;
  - the struct {sign, zero, nar, body, guard, sticky} for the S1→S2 register.
- Sub-module posit_round holds the S2 combinational logic: RNE increment, saturation, negation. It is instantiated once and is reusable by the multiplier.

## Test plan
All cases use N=8, ES=3, out_ready = 1 unless stated.
- **Basic field placement.** Sign 0, k=0, exp=3'b101, frac=0 → 0x54. Repeat with k=−1 → 0x34. out_valid rises exactly 2 cycles after the transfer.
- **Negative value.** Sign 1, k=0, exp=0, frac=0 → 0xC0.
- **Tie rounding.** k=0, exp=0, frac=8'b0110_0000 (tie, lsb 1) → 0x42. With frac=8'b0010_0000 (tie, lsb 0) → 0x40.
- **Saturation.**
  - k=7 → 0x7F.
  - k=−7 → 0x01.
  - Sign 1 with k=7 → 0x81.
  - in_nar → 0x80; in_zero → 0x00.
- **Backpressure.** Hold out_ready = 0 and send 3 inputs. in_ready drops after 2 accepted, and the first out_posit stays stable. Release out_ready: the 3 results appear in order on consecutive cycles.
- **Reset mid-stream.** Assert reset with both stages full. Next cycle: out_valid = 0, out_posit = 0, in_ready = 1, and no stale output follows.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit constants, special-pattern helpers and the S1->S2 pipeline record.
package posit_pkg;

    localparam int N  = 8;           // posit width
    localparam int ES = 3;           // exponent field width
    localparam int RS = $clog2(N);   // regime index width
    localparam int KW = RS + 1;      // signed regime value width
    localparam int FW = N;           // input fraction width
    localparam int BW = N - 1;       // magnitude body width (posit minus sign)
    // Build vector: 2-bit regime seed, exponent, fraction, plus zero padding
    // wide enough that the largest regime shift never drops real payload bits.
    localparam int VW = 2 + ES + FW + N;

    // Regime values at or beyond these bounds saturate the magnitude.
    localparam logic signed [KW-1:0] K_SAT_HI = KW'(N - 2);
    localparam logic signed [KW-1:0] K_SAT_LO = KW'(-(N - 1));

    // Fields handed from the body-build stage to the rounding stage.
    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          nar;
        logic [BW-1:0] body;
        logic          guard;
        logic          sticky;
    } s1_fields_t;

    localparam int S1W = $bits(s1_fields_t);

    // Not-a-Real encoding: sign bit set, everything else clear.
    function automatic logic [N-1:0] nar_pattern();
        return {1'b1, {(N - 1){1'b0}}};
    endfunction

    // Zero encoding: all bits clear.
    function automatic logic [N-1:0] zero_pattern();
        return {N{1'b0}};
    endfunction

    // Largest positive magnitude body.
    function automatic logic [BW-1:0] maxpos_mag();
        return {BW{1'b1}};
    endfunction

    // Smallest positive magnitude body.
    function automatic logic [BW-1:0] minpos_mag();
        return {{(BW - 1){1'b0}}, 1'b1};
    endfunction

    // True when the regime value is too large to represent.
    function automatic logic k_sat_high(input logic [KW-1:0] k);
        return $signed(k) >= K_SAT_HI;
    endfunction

    // True when the regime value is too small to represent.
    function automatic logic k_sat_low(input logic [KW-1:0] k);
        return $signed(k) <= K_SAT_LO;
    endfunction

endpackage

// File: rtl/posit_round.sv
// Posit finishing logic: round-to-nearest-even on the magnitude body, clamp
// away from NaR and zero, then apply the sign by two's complement.
module posit_round
    import posit_pkg::*;
(
    input  s1_fields_t     fields,
    output logic [N-1:0]   posit
);

    logic          round_up_s;
    logic [BW:0]   sum_s;
    logic [BW-1:0] mag_s;
    logic [N-1:0]  unsigned_s;

    // Round, saturate and negate; specials override the arithmetic path.
    always_comb begin
        round_up_s = fields.guard & (fields.body[0] | fields.sticky);
        sum_s      = {1'b0, fields.body} + {{BW{1'b0}}, round_up_s};

        // A carry out of the body would alias NaR; an empty body would alias zero.
        if (sum_s[BW]) begin
            mag_s = maxpos_mag();
        end else if (sum_s[BW-1:0] == {BW{1'b0}}) begin
            mag_s = minpos_mag();
        end else begin
            mag_s = sum_s[BW-1:0];
        end

        unsigned_s = {1'b0, mag_s};

        if (fields.nar) begin
            posit = nar_pattern();
        end else if (fields.zero) begin
            posit = zero_pattern();
        end else if (fields.sign) begin
            posit = (~unsigned_s) + {{(N - 1){1'b0}}, 1'b1};
        end else begin
            posit = unsigned_s;
        end
    end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage posit packer: S1 builds the regime/exponent/fraction body and
// extracts guard/sticky, S2 rounds, saturates and applies the sign.
module posit_encoder
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic          in_zero,
    input  logic          in_nar,
    input  logic [KW-1:0] in_k,
    input  logic [ES-1:0] in_exp,
    input  logic [FW-1:0] in_frac,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
);

    logic             s2_load_s;
    logic             in_fire_s;
    logic [RS-1:0]    shamt_s;
    logic [VW-1:0]    seed_s;
    logic [VW-1:0]    vec_s;
    s1_fields_t       s1_next_s;
    s1_fields_t       s1_r;
    logic             s1_valid_r;
    logic [N-1:0]     round_posit_s;
    logic             out_valid_r;
    logic [N-1:0]     out_posit_r;

    // Handshake: S2 loads when empty or drained; S1 accepts when empty or moving on.
    always_comb begin
        s2_load_s = (~out_valid_r) | out_ready;
        in_ready  = (~s1_valid_r) | s2_load_s;
        in_fire_s = in_valid & in_ready;
    end

    // Regime generation by shifting a seed: ones shift in for k >= 0,
    // zeros for k < 0 (~k equals -k-1 in two's complement).
    always_comb begin
        if (in_k[KW-1]) begin
            shamt_s = ~in_k[RS-1:0];
            seed_s  = {2'b01, in_exp, in_frac, {N{1'b0}}};
            vec_s   = seed_s >> shamt_s;
        end else begin
            shamt_s = in_k[RS-1:0];
            seed_s  = {2'b10, in_exp, in_frac, {N{1'b0}}};
            vec_s   = $unsigned($signed(seed_s) >>> shamt_s);
        end
    end

    // Next S1 contents: specials, regime saturation, or the built body.
    always_comb begin
        s1_next_s.sign = in_sign;
        s1_next_s.nar  = in_nar;
        s1_next_s.zero = in_zero & ~in_nar;
        if (k_sat_high(in_k)) begin
            s1_next_s.body   = maxpos_mag();
            s1_next_s.guard  = 1'b0;
            s1_next_s.sticky = 1'b0;
        end else if (k_sat_low(in_k)) begin
            s1_next_s.body   = minpos_mag();
            s1_next_s.guard  = 1'b0;
            s1_next_s.sticky = 1'b0;
        end else begin
            s1_next_s.body   = vec_s[VW-1 -: BW];
            s1_next_s.guard  = vec_s[VW-1-BW];
            s1_next_s.sticky = |vec_s[VW-2-BW:0];
        end
    end

    // S1 register: capture on input transfer, empty when its entry moves to S2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_r       <= s1_fields_t'({S1W{1'b0}});
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_r       <= s1_next_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
            s1_r       <= s1_r;
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_r       <= s1_r;
        end
    end

    posit_round u_round (
        .fields (s1_r),
        .posit  (round_posit_s)
    );

    // S2 register: take the rounded result when allowed, hold it under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_posit_r <= {N{1'b0}};
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_posit_r <= round_posit_s;
            end else begin
                out_posit_r <= out_posit_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_posit_r <= out_posit_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_posit = out_posit_r;

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder (N=8, ES=3).
module tb_posit_encoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic       in_zero;
    logic       in_nar;
    logic [3:0] in_k;
    logic [2:0] in_exp;
    logic [7:0] in_frac;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_posit;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];

    posit_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_k      (in_k),
        .in_exp    (in_exp),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every output transfer must match the oldest expected value.
    always @(negedge clk) begin
        logic [7:0] expv;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %02h expected none", out_posit);
            end else begin
                expv = sb_q.pop_front();
                if (out_posit !== expv) begin
                    errors++;
                    $display("FAIL scoreboard got %02h expected %02h", out_posit, expv);
                end
            end
        end
    end

    task automatic set_fields(input logic s, input logic z, input logic n,
                              input logic [3:0] k, input logic [2:0] e, input logic [7:0] f);
        in_sign = s;
        in_zero = z;
        in_nar  = n;
        in_k    = k;
        in_exp  = e;
        in_frac = f;
    endtask

    // Present one input, wait (bounded) for acceptance, record its expected result.
    task automatic send(input logic s, input logic z, input logic n, input logic [3:0] k,
                        input logic [2:0] e, input logic [7:0] f, input logic [7:0] expv);
        int waited = 0;
        set_fields(s, z, n, k, e, f);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready got %0b expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(expv);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for all expected results, then let the pipeline settle.
    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_fields(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b expected 0", out_valid);
        end
        checks++;
        if (out_posit !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_posit got %02h expected 00", out_posit);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b101, 8'h00, 8'h54);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid got %0b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_two out_valid got %0b expected 1", out_valid);
        end
        @(posedge clk);
        #1;
        send(1'b0, 1'b0, 1'b0, 4'(-1), 3'b101, 8'h00, 8'h34);
        drain();
    endtask

    task automatic test_negative();
        send(1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 8'h00, 8'hC0);
        send(1'b1, 1'b0, 1'b0, 4'd2, 3'b011, 8'b1010_0000, 8'h8C);
        drain();
    endtask

    task automatic test_rounding();
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b000, 8'b0110_0000, 8'h42);
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b000, 8'b0010_0000, 8'h40);
        send(1'b0, 1'b0, 1'b0, 4'd2, 3'b011, 8'b1010_0000, 8'h74);
        send(1'b0, 1'b0, 1'b0, 4'd5, 3'b100, 8'h00, 8'h7E);
        send(1'b0, 1'b0, 1'b0, 4'd5, 3'b110, 8'h00, 8'h7F);
        send(1'b0, 1'b0, 1'b0, 4'(-6), 3'b111, 8'h00, 8'h02);
        drain();
    endtask

    task automatic test_saturation();
        send(1'b0, 1'b0, 1'b0, 4'd7, 3'b000, 8'h00, 8'h7F);
        send(1'b0, 1'b0, 1'b0, 4'd6, 3'b010, 8'hFF, 8'h7F);
        send(1'b0, 1'b0, 1'b0, 4'(-7), 3'b000, 8'h00, 8'h01);
        send(1'b0, 1'b0, 1'b0, 4'(-8), 3'b111, 8'hFF, 8'h01);
        send(1'b1, 1'b0, 1'b0, 4'd7, 3'b000, 8'h00, 8'h81);
        send(1'b1, 1'b0, 1'b0, 4'(-7), 3'b000, 8'h00, 8'hFF);
        drain();
    endtask

    task automatic test_specials();
        send(1'b0, 1'b0, 1'b1, 4'd3, 3'b101, 8'hAA, 8'h80);
        send(1'b1, 1'b1, 1'b1, 4'd0, 3'b000, 8'h00, 8'h80);
        send(1'b0, 1'b1, 1'b0, 4'd3, 3'b101, 8'hAA, 8'h00);
        send(1'b1, 1'b1, 1'b0, 4'(-2), 3'b001, 8'h11, 8'h00);
        drain();
    endtask

    task automatic test_back_to_back();
        send(1'b0, 1'b0, 1'b0, 4'(-3), 3'b010, 8'h00, 8'h0A);
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b101, 8'h00, 8'h54);
        send(1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 8'h00, 8'hC0);
        send(1'b0, 1'b0, 1'b0, 4'(-1), 3'b101, 8'h00, 8'h34);
        send(1'b0, 1'b1, 1'b0, 4'd0, 3'b000, 8'h00, 8'h00);
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b101, 8'h00, 8'h54);
        send(1'b0, 1'b0, 1'b0, 4'(-1), 3'b101, 8'h00, 8'h34);
        set_fields(1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 8'h00);
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %0b expected 0", in_ready);
        end
        checks++;
        if (out_posit !== 8'h54 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_head got %02h valid %0b expected 54 valid 1", out_posit, out_valid);
        end
        held = out_posit;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_posit !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got %02h ready %0b expected %02h ready 0", out_posit, in_ready, held);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %0b expected 1", in_ready);
        end
        sb_q.push_back(8'hC0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_consecutive cycle %0d got %0b expected 1", i, out_valid);
            end
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 4'd7, 3'b000, 8'h00, 8'h7F);
        send(1'b0, 1'b0, 1'b0, 4'd0, 3'b101, 8'h00, 8'h54);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_posit !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state got valid %0b posit %02h ready %0b expected 0 00 1",
                     out_valid, out_posit, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_stale got %0d outputs expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_rounding();
        test_saturation();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
